// File: rtl/wave_mux_n_if.sv
// Sample/select bus of the wave_mux_n DAC waveform selector.
// master drives key, select strobe and sample inputs; slave is the selector itself.
interface wave_mux_n_if #(
    parameter int DW  = 14,
    parameter int NCH = 4,
    parameter int SW  = 4
);
    logic              key_n;
    logic              sel_wr;
    logic [SW-1:0]     sel_idx;
    logic [NCH*DW-1:0] da_in;
    logic [DW-1:0]     da_out;
    logic [SW-1:0]     cur_sel;
    logic              busy;
    logic              sel_err;

    modport master (
        output key_n, sel_wr, sel_idx, da_in,
        input  da_out, cur_sel, busy, sel_err
    );

    modport slave (
        input  key_n, sel_wr, sel_idx, da_in,
        output da_out, cur_sel, busy, sel_err
    );
endinterface

// File: rtl/wave_mux_n.sv
// N-channel DAC waveform selector with key debouncer and register select port.
// Define WAVE_MUX_ZC_SWITCH_EN to defer channel changes to a midscale crossing (or timeout).
module wave_mux_n #(
    parameter int DW         = 14,
    parameter int NCH        = 4,
    parameter int SW         = 4,
    parameter int DEB_CYC    = 1_000_000,
    parameter int ZC_TIMEOUT = 4096
) (
    input logic        clk,
    input logic        rst_n,
    wave_mux_n_if.slave bus
);
    localparam int CW = $clog2(DEB_CYC) + 1;

    if (NCH < 2 || NCH > 16 || (1 << SW) < NCH || DEB_CYC < 2 || ZC_TIMEOUT < 2) begin : g_bad_param
        $error("wave_mux_n: illegal parameter set");
    end

    logic          key_m, key_s, key_st, key_st_d;
    logic [CW-1:0] deb_cnt;
    logic          press;
    logic [SW-1:0] tgt, cur_sel;
    logic [DW-1:0] da_out, sel_sample;
    logic          busy, sel_err;
    logic          idx_ok;

    assign press      = key_st_d & ~key_st;
    assign idx_ok     = {1'b0, bus.sel_idx} < (SW+1)'(NCH);
    assign sel_sample = bus.da_in[int'(cur_sel) * DW +: DW];

    // Key is idle-high, so the synchroniser and stable level reset to 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_m    <= 1'b1;
            key_s    <= 1'b1;
            key_st   <= 1'b1;
            key_st_d <= 1'b1;
            deb_cnt  <= '0;
        end else begin
            key_m    <= bus.key_n;
            key_s    <= key_m;
            key_st_d <= key_st;
            if (key_s != key_st) begin
                if (deb_cnt == CW'(DEB_CYC - 1)) begin
                    key_st  <= key_s;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    // A register write always has priority; a coincident key press is discarded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tgt     <= '0;
            sel_err <= 1'b0;
        end else begin
            sel_err <= 1'b0;
            if (bus.sel_wr) begin
                if (idx_ok) tgt <= bus.sel_idx;
                else        sel_err <= 1'b1;
            end else if (press) begin
                tgt <= (tgt == SW'(NCH - 1)) ? '0 : tgt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            da_out <= DW'(1) << (DW - 1);
            busy   <= 1'b0;
        end else begin
            da_out <= sel_sample;
            busy   <= (tgt != cur_sel);
        end
    end

`ifdef WAVE_MUX_ZC_SWITCH_EN
    localparam int TW = $clog2(ZC_TIMEOUT) + 1;

    typedef enum logic {ZC_IDLE, ZC_WAIT} zc_state_e;

    zc_state_e     zc_state, zc_next;
    logic [TW-1:0] zc_cnt;
    logic          msb_prev;
    logic          crossing;
    logic          switch_now;

    assign crossing = sel_sample[DW-1] != msb_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zc_state <= ZC_IDLE;
            zc_cnt   <= '0;
            msb_prev <= 1'b0;
            cur_sel  <= '0;
        end else begin
            zc_state <= zc_next;
            msb_prev <= sel_sample[DW-1];
            if (switch_now) cur_sel <= tgt;
            if (zc_state == ZC_IDLE || switch_now) zc_cnt <= '0;
            else                                   zc_cnt <= zc_cnt + 1'b1;
        end
    end

    // Crossing and timeout in the same cycle collapse into one switch.
    always_comb begin
        zc_next    = zc_state;
        switch_now = 1'b0;
        case (zc_state)
            ZC_IDLE: begin
                if (tgt != cur_sel) zc_next = ZC_WAIT;
            end
            ZC_WAIT: begin
                if (tgt == cur_sel) begin
                    zc_next = ZC_IDLE;
                end else if (crossing || zc_cnt == TW'(ZC_TIMEOUT - 1)) begin
                    switch_now = 1'b1;
                    zc_next    = ZC_IDLE;
                end
            end
            default: zc_next = ZC_IDLE;
        endcase
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n) cur_sel <= '0;
        else        cur_sel <= tgt;
    end
`endif

    assign bus.da_out  = da_out;
    assign bus.cur_sel = cur_sel;
    assign bus.busy    = busy;
    assign bus.sel_err = sel_err;
endmodule

// File: tb/tb_wave_mux_n.sv
// Self-checking bench for wave_mux_n: directed key/select scenarios plus randomized
// register-select traffic compared against a cycle-level behavioural model.
module tb_wave_mux_n;
    localparam int DW  = 14;
    localparam int NCH = 4;
    localparam int SW  = 4;
    localparam int DEB = 8;
    localparam int ZCT = 16;
    localparam logic [DW-1:0] MID = 14'h2000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic [DW-1:0] ch [NCH];

    wave_mux_n_if #(.DW(DW), .NCH(NCH), .SW(SW)) bus ();

    wave_mux_n #(
        .DW(DW), .NCH(NCH), .SW(SW), .DEB_CYC(DEB), .ZC_TIMEOUT(ZCT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [SW-1:0] idx);
        bus.sel_wr  = wr;
        bus.sel_idx = idx;
        for (int k = 0; k < NCH; k++) bus.da_in[k*DW +: DW] = ch[k];
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One clean press: held long enough to debounce, then released just as long.
    task automatic pressKey();
        bus.key_n = 1'b0;
        tick(DEB + 6);
        bus.key_n = 1'b1;
        tick(DEB + 6);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
    endtask

`ifndef WAVE_MUX_ZC_SWITCH_EN
    task automatic randomRun(input int cycles);
        logic [SW-1:0] m_tgt, m_cur, n_tgt, n_cur, idx;
        logic [DW-1:0] m_out, n_out;
        logic          m_busy, m_err, n_busy, n_err, wr;
        m_tgt = '0; m_cur = '0; m_out = MID; m_busy = 1'b0; m_err = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            for (int k = 0; k < NCH; k++) ch[k] = DW'($urandom_range(0, (1 << DW) - 1));
            wr  = ($urandom_range(0, 3) == 0);
            idx = SW'($urandom_range(0, 7));
            applyStimulus(wr, idx);
            // Target follows valid writes; current trails target by one clock; output trails current.
            n_out  = ch[m_cur];
            n_cur  = m_tgt;
            n_busy = (m_tgt != m_cur);
            n_err  = wr && (idx >= NCH);
            n_tgt  = (wr && idx < NCH) ? idx : m_tgt;
            tick(1);
            checkOutput("rnd_da_out",  32'(bus.da_out),  32'(n_out));
            checkOutput("rnd_cur_sel", 32'(bus.cur_sel), 32'(n_cur));
            checkOutput("rnd_busy",    32'(bus.busy),    32'(n_busy));
            checkOutput("rnd_sel_err", 32'(bus.sel_err), 32'(n_err));
            m_tgt = n_tgt; m_cur = n_cur; m_out = n_out; m_busy = n_busy; m_err = n_err;
        end
        applyStimulus(1'b0, '0);
    endtask
`endif

    initial begin
        bus.key_n = 1'b1;
        ch[0] = 14'h0111; ch[1] = 14'h0222; ch[2] = 14'h0333; ch[3] = 14'h0444;
        applyStimulus(1'b0, '0);
        rst_n = 1'b0;
        tick(3);
        checkOutput("rst_da_out",  32'(bus.da_out),  32'(MID));
        checkOutput("rst_cur_sel", 32'(bus.cur_sel), 32'd0);
        checkOutput("rst_busy",    32'(bus.busy),    32'd0);
        checkOutput("rst_sel_err", 32'(bus.sel_err), 32'd0);
        rst_n = 1'b1;
        tick(1);
        checkOutput("rel_da_out",  32'(bus.da_out),  32'(ch[0]));

`ifndef WAVE_MUX_ZC_SWITCH_EN
        for (int i = 1; i <= 4; i++) begin
            pressKey();
            checkOutput($sformatf("wrap%0d", i), 32'(bus.cur_sel), 32'(i % NCH));
        end

        for (int i = 0; i < 10; i++) begin
            bus.key_n = ~bus.key_n;
            tick(3);
        end
        checkOutput("bounce_nopress", 32'(bus.cur_sel), 32'd0);
        bus.key_n = 1'b0;
        tick(DEB);
        checkOutput("deb_early", 32'(bus.cur_sel), 32'd0);
        tick(6);
        checkOutput("deb_press", 32'(bus.cur_sel), 32'd1);
        bus.key_n = 1'b1;
        tick(DEB + 6);
        checkOutput("deb_release", 32'(bus.cur_sel), 32'd1);

        applyStimulus(1'b1, 4'd2);
        tick(1);
        applyStimulus(1'b0, '0);
        checkOutput("wr_n1_cur",  32'(bus.cur_sel), 32'd1);
        checkOutput("wr_n1_busy", 32'(bus.busy),    32'd0);
        tick(1);
        checkOutput("wr_n2_cur",  32'(bus.cur_sel), 32'd2);
        checkOutput("wr_n2_busy", 32'(bus.busy),    32'd1);
        tick(1);
        checkOutput("wr_n3_da",   32'(bus.da_out),  32'(ch[2]));
        checkOutput("wr_n3_busy", 32'(bus.busy),    32'd0);

        applyStimulus(1'b1, 4'd5);
        tick(1);
        applyStimulus(1'b0, '0);
        checkOutput("err_pulse", 32'(bus.sel_err), 32'd1);
        tick(1);
        checkOutput("err_clear", 32'(bus.sel_err), 32'd0);
        tick(2);
        checkOutput("err_cur",   32'(bus.cur_sel), 32'd2);
        checkOutput("err_busy",  32'(bus.busy),    32'd0);

        // Key falls DEB+2 clocks after key_n low; the write lands on the press cycle.
        bus.key_n = 1'b0;
        tick(DEB + 2);
        applyStimulus(1'b1, 4'd2);
        tick(1);
        applyStimulus(1'b0, '0);
        tick(4);
        checkOutput("collide_cur", 32'(bus.cur_sel), 32'd2);
        bus.key_n = 1'b1;
        tick(DEB + 6);
        checkOutput("collide_rel", 32'(bus.cur_sel), 32'd2);

        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        randomRun(300);
`else
        ch[0] = 14'h0100;
        applyStimulus(1'b1, 4'd1);
        tick(1);
        applyStimulus(1'b0, '0);
        tick(9);
        checkOutput("zc_to_hold", 32'(bus.cur_sel), 32'd0);
        checkOutput("zc_to_busy", 32'(bus.busy),    32'd1);
        tick(12);
        checkOutput("zc_to_done", 32'(bus.cur_sel), 32'd1);

        doReset();
        ch[0] = 14'h1FF0;
        applyStimulus(1'b0, '0);
        tick(4);
        applyStimulus(1'b1, 4'd1);
        tick(1);
        applyStimulus(1'b0, '0);
        tick(4);
        checkOutput("zc_x_hold", 32'(bus.cur_sel), 32'd0);
        checkOutput("zc_x_busy", 32'(bus.busy),    32'd1);
        ch[0] = 14'h2010;
        applyStimulus(1'b0, '0);
        tick(4);
        checkOutput("zc_x_done", 32'(bus.cur_sel), 32'd1);

        doReset();
        ch[0] = 14'h0100;
        applyStimulus(1'b1, 4'd3);
        tick(1);
        applyStimulus(1'b0, '0);
        tick(4);
        doReset();
        tick(25);
        checkOutput("zc_rst_cur",  32'(bus.cur_sel), 32'd0);
        checkOutput("zc_rst_busy", 32'(bus.busy),    32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
